// File: rtl/adc_wave_monitor.sv
// -----------------------------------------------------------------------------
// adc_wave_monitor
//
// Measures a stream of 10-bit unsigned converter samples over fixed windows of
// 2^WIN_LOG2 accepted samples. For every completed window it reports the
// minimum, maximum, number of rising threshold crossings and the most recent
// crossing-to-crossing period (in accepted samples). The crossing threshold
// tracks the signal: at each window close it moves to the mid-point of that
// window's min and max. A hysteresis band of +/-HYST LSBs around the threshold
// suppresses chatter.
//
// Parameters
//   WIN_LOG2     log2 of the window length in accepted samples (4..16)
//   HYST         hysteresis half-width in LSBs (0..255)
//
// Ports
//   dac_clk      sole clock, rising edge
//   rst          synchronous active-high reset
//   sample_valid qualifies sample; idle cycles change no measurement state
//   sample       10-bit unsigned converter code
//   meas_valid   one-cycle pulse, results below were updated on this cycle
//   min_out      minimum sample of the last completed window
//   max_out      maximum sample of the last completed window
//   cross_cnt    rising crossings in the last window (saturates at 255)
//   period_out   samples between the two most recent rising crossings
//                (0 until two crossings have been seen, saturates at 65535)
//   thr_out      crossing threshold currently in use
// -----------------------------------------------------------------------------
module adc_wave_monitor #(
  parameter int WIN_LOG2 = 12,
  parameter int HYST     = 8
) (
  input  logic        dac_clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [9:0]  sample,
  output logic        meas_valid,
  output logic [9:0]  min_out,
  output logic [9:0]  max_out,
  output logic [7:0]  cross_cnt,
  output logic [15:0] period_out,
  output logic [9:0]  thr_out
);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } cross_state_t;

  localparam logic [10:0]         HYST_W    = 11'(HYST);
  localparam logic [WIN_LOG2-1:0] WCNT_ZERO = {WIN_LOG2{1'b0}};
  localparam logic [WIN_LOG2-1:0] WCNT_LAST = {WIN_LOG2{1'b1}};

  // Tracking state
  cross_state_t        state_r;
  logic [WIN_LOG2-1:0] wcnt_r;
  logic [9:0]          min_r;
  logic [9:0]          max_r;
  logic [7:0]          cross_r;
  logic [15:0]         scnt_r;
  logic                seen_edge_r;
  logic [15:0]         last_period_r;
  logic [9:0]          thr_r;

  // Registered results
  logic                meas_valid_r;
  logic [9:0]          min_out_r;
  logic [9:0]          max_out_r;
  logic [7:0]          cross_out_r;
  logic [15:0]         period_out_r;

  // Combinational next values for an accepted sample
  logic [10:0]         hi_sum_s;
  logic [10:0]         lo_diff_s;
  logic [9:0]          hi_lvl_s;
  logic [9:0]          lo_lvl_s;
  logic                first_s;
  logic                last_s;
  logic                rise_s;
  cross_state_t        state_nxt_s;
  logic [9:0]          min_nxt_s;
  logic [9:0]          max_nxt_s;
  logic [7:0]          cross_base_s;
  logic [7:0]          cross_nxt_s;
  logic [15:0]         scnt_nxt_s;
  logic [15:0]         period_nxt_s;
  logic [10:0]         thr_sum_s;
  logic [9:0]          thr_nxt_s;

  // Hysteresis levels, clamped to the 10-bit code range.
  always_comb begin
    hi_sum_s  = {1'b0, thr_r} + HYST_W;
    lo_diff_s = {1'b0, thr_r} - HYST_W;
    if (hi_sum_s > 11'd1023) begin
      hi_lvl_s = 10'd1023;
    end else begin
      hi_lvl_s = hi_sum_s[9:0];
    end
    // thr <= 1023 and HYST <= 255, so bit 10 is set only when the difference went negative
    if (lo_diff_s[10]) begin
      lo_lvl_s = 10'd0;
    end else begin
      lo_lvl_s = lo_diff_s[9:0];
    end
  end

  // Crossing detection and next hysteresis state.
  always_comb begin
    rise_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_LOW: begin
        if (sample >= hi_lvl_s) begin
          rise_s      = 1'b1;
          state_nxt_s = ST_HIGH;
        end else begin
          state_nxt_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (sample <= lo_lvl_s) begin
          state_nxt_s = ST_LOW;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: begin
        state_nxt_s = ST_LOW;
      end
    endcase
  end

  // Window trackers: min/max/crossing count, the first sample reloads them.
  always_comb begin
    first_s = (wcnt_r == WCNT_ZERO);
    last_s  = (wcnt_r == WCNT_LAST);
    if (first_s) begin
      min_nxt_s    = sample;
      max_nxt_s    = sample;
      cross_base_s = 8'd0;
    end else begin
      min_nxt_s    = (sample <= min_r) ? sample : min_r;
      max_nxt_s    = (sample >= max_r) ? sample : max_r;
      cross_base_s = cross_r;
    end
    if (rise_s && (cross_base_s != 8'd255)) begin
      cross_nxt_s = cross_base_s + 8'd1;
    end else begin
      cross_nxt_s = cross_base_s;
    end
    // Mid-point of the window, 11-bit sum so min+max cannot overflow
    thr_sum_s = {1'b0, min_nxt_s} + {1'b0, max_nxt_s};
    thr_nxt_s = 10'(thr_sum_s >> 1);
  end

  // Sample counter since last crossing and the derived period.
  always_comb begin
    if (rise_s && seen_edge_r) begin
      if (scnt_r == 16'hFFFF) begin
        period_nxt_s = 16'hFFFF;
      end else begin
        period_nxt_s = scnt_r + 16'd1;
      end
    end else begin
      period_nxt_s = last_period_r;
    end
    if (rise_s) begin
      scnt_nxt_s = 16'd0;
    end else if (scnt_r != 16'hFFFF) begin
      scnt_nxt_s = scnt_r + 16'd1;
    end else begin
      scnt_nxt_s = scnt_r;
    end
  end

  // State update: only accepted samples advance anything; results load at window close.
  always_ff @(posedge dac_clk) begin
    if (rst) begin
      state_r       <= ST_LOW;
      wcnt_r        <= WCNT_ZERO;
      min_r         <= 10'd0;
      max_r         <= 10'd0;
      cross_r       <= 8'd0;
      scnt_r        <= 16'd0;
      seen_edge_r   <= 1'b0;
      last_period_r <= 16'd0;
      thr_r         <= 10'd512;
      meas_valid_r  <= 1'b0;
      min_out_r     <= 10'd0;
      max_out_r     <= 10'd0;
      cross_out_r   <= 8'd0;
      period_out_r  <= 16'd0;
    end else begin
      meas_valid_r <= 1'b0;
      if (sample_valid) begin
        state_r       <= state_nxt_s;
        wcnt_r        <= wcnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        min_r         <= min_nxt_s;
        max_r         <= max_nxt_s;
        cross_r       <= cross_nxt_s;
        scnt_r        <= scnt_nxt_s;
        last_period_r <= period_nxt_s;
        if (rise_s) begin
          seen_edge_r <= 1'b1;
        end
        if (last_s) begin
          meas_valid_r <= 1'b1;
          min_out_r    <= min_nxt_s;
          max_out_r    <= max_nxt_s;
          cross_out_r  <= cross_nxt_s;
          period_out_r <= period_nxt_s;
          thr_r        <= thr_nxt_s;
        end
      end
    end
  end

  assign meas_valid = meas_valid_r;
  assign min_out    = min_out_r;
  assign max_out    = max_out_r;
  assign cross_cnt  = cross_out_r;
  assign period_out = period_out_r;
  assign thr_out    = thr_r;

endmodule

// File: tb/tb_adc_wave_monitor.sv
// -----------------------------------------------------------------------------
// Bench for adc_wave_monitor. Two instances: a (WIN_LOG2=12) for sawtooth
// windows, b (WIN_LOG2=4) for short hand-built windows. Stimulus pushes the
// expected result record (including the cycle the pulse must appear in) into
// a per-instance queue; monitors pop and compare on every meas_valid pulse.
// -----------------------------------------------------------------------------
module tb_adc_wave_monitor;

  logic dac_clk = 1'b0;
  always #5 dac_clk = ~dac_clk;

  logic        a_rst = 1'b1, a_valid = 1'b0;
  logic [9:0]  a_sample = 10'd0;
  logic        a_meas_valid;
  logic [9:0]  a_min, a_max, a_thr;
  logic [7:0]  a_cross;
  logic [15:0] a_period;

  logic        b_rst = 1'b1, b_valid = 1'b0;
  logic [9:0]  b_sample = 10'd0;
  logic        b_meas_valid;
  logic [9:0]  b_min, b_max, b_thr;
  logic [7:0]  b_cross;
  logic [15:0] b_period;

  adc_wave_monitor #(.WIN_LOG2(12), .HYST(8)) dut_a (
    .dac_clk(dac_clk), .rst(a_rst), .sample_valid(a_valid), .sample(a_sample),
    .meas_valid(a_meas_valid), .min_out(a_min), .max_out(a_max),
    .cross_cnt(a_cross), .period_out(a_period), .thr_out(a_thr)
  );

  adc_wave_monitor #(.WIN_LOG2(4), .HYST(8)) dut_b (
    .dac_clk(dac_clk), .rst(b_rst), .sample_valid(b_valid), .sample(b_sample),
    .meas_valid(b_meas_valid), .min_out(b_min), .max_out(b_max),
    .cross_cnt(b_cross), .period_out(b_period), .thr_out(b_thr)
  );

  typedef struct {
    int     mn;
    int     mx;
    int     cr;
    int     per;
    int     thr;
    longint cyc;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     checks = 0;
  int     failures = 0;
  longint pcyc = 0;

  always @(posedge dac_clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, pcyc);
    end
  endtask

  // Monitor for instance a
  always @(negedge dac_clk) begin
    exp_t e;
    if (a_meas_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pulse", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_pulse_cycle", pcyc, e.cyc);
        chk("a_min", a_min, e.mn);
        chk("a_max", a_max, e.mx);
        chk("a_cross", a_cross, e.cr);
        chk("a_period", a_period, e.per);
        chk("a_thr", a_thr, e.thr);
      end
    end
  end

  // Monitor for instance b
  always @(negedge dac_clk) begin
    exp_t e;
    if (b_meas_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pulse", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_pulse_cycle", pcyc, e.cyc);
        chk("b_min", b_min, e.mn);
        chk("b_max", b_max, e.mx);
        chk("b_cross", b_cross, e.cr);
        chk("b_period", b_period, e.per);
        chk("b_thr", b_thr, e.thr);
      end
    end
  end

  // Drive one cycle of inputs on the falling edge; captured at the next rising edge.
  task automatic drv(input bit which, input logic v, input logic [9:0] s, input logic r);
    @(negedge dac_clk);
    if (which) begin
      b_valid = v; b_sample = s; b_rst = r;
    end else begin
      a_valid = v; a_sample = s; a_rst = r;
    end
  endtask

  // Call right after driving a window's last sample: pulse due one cycle later.
  task automatic expect_pulse(input bit which, input int mn, input int mx,
                              input int cr, input int per, input int thr);
    exp_t e;
    e.mn = mn; e.mx = mx; e.cr = cr; e.per = per; e.thr = thr;
    e.cyc = pcyc + 1;
    if (which) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic check_reset_outputs(input bit which);
    if (which) begin
      chk("b_rst_meas_valid", b_meas_valid, 0);
      chk("b_rst_min", b_min, 0);
      chk("b_rst_max", b_max, 0);
      chk("b_rst_cross", b_cross, 0);
      chk("b_rst_period", b_period, 0);
      chk("b_rst_thr", b_thr, 512);
    end else begin
      chk("a_rst_meas_valid", a_meas_valid, 0);
      chk("a_rst_min", a_min, 0);
      chk("a_rst_max", a_max, 0);
      chk("a_rst_cross", a_cross, 0);
      chk("a_rst_period", a_period, 0);
      chk("a_rst_thr", a_thr, 512);
    end
  endtask

  task automatic do_reset(input bit which);
    drv(which, 1'b0, 10'd0, 1'b1);
    drv(which, 1'b0, 10'd0, 1'b1);
    drv(which, 1'b0, 10'd0, 1'b0);
    check_reset_outputs(which);
  endtask

  // Window 3 of instance b: exercises the clamped low level (thr = 0).
  logic [9:0] w3 [16] = '{10'd7, 10'd8, 10'd1, 10'd9, 10'd0, 10'd8,
                          10'd5, 10'd5, 10'd5, 10'd5, 10'd5, 10'd5,
                          10'd5, 10'd5, 10'd5, 10'd5};

  initial begin
    // ---------------- Instance a: WIN_LOG2=12, HYST=8 ----------------
    do_reset(1'b0);
    // Continuous sawtooth: crossings at 520,1544,2568,3592
    for (int i = 0; i < 4096; i++) begin
      drv(1'b0, 1'b1, 10'(i % 1024), 1'b0);
      if (i == 4095) expect_pulse(1'b0, 0, 1023, 4, 1024, 511);
    end
    drv(1'b0, 1'b0, 10'd0, 1'b0);

    // Same sawtooth with sample_valid toggling; idle cycles carry junk data
    do_reset(1'b0);
    for (int i = 0; i < 4096; i++) begin
      drv(1'b0, 1'b1, 10'(i % 1024), 1'b0);
      if (i == 4095) expect_pulse(1'b0, 0, 1023, 4, 1024, 511);
      drv(1'b0, 1'b0, 10'd1023, 1'b0);
    end

    // Reset mid-window (with valid high): partial window discarded, thr back to 512
    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) drv(1'b0, 1'b1, 10'(i % 1024), 1'b0);
    drv(1'b0, 1'b1, 10'd1000, 1'b1);
    drv(1'b0, 1'b0, 10'd0, 1'b0);
    check_reset_outputs(1'b0);
    for (int i = 0; i < 4096; i++) begin
      drv(1'b0, 1'b1, 10'(i % 1024), 1'b0);
      if (i == 4095) expect_pulse(1'b0, 0, 1023, 4, 1024, 511);
    end
    drv(1'b0, 1'b0, 10'd0, 1'b0);

    // ---------------- Instance b: WIN_LOG2=4, HYST=8 ----------------
    // Constant 300 for two windows
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) begin
      drv(1'b1, 1'b1, 10'd300, 1'b0);
      if (i == 15 || i == 31) expect_pulse(1'b1, 300, 300, 0, 0, 300);
    end

    // Crossing at index 4 and exactly at index 15 (period 11)
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, (i == 4 || i == 15) ? 10'd600 : 10'd0, 1'b0);
      if (i == 15) expect_pulse(1'b1, 0, 600, 2, 11, 300);
      if (i == 7) drv(1'b1, 1'b0, 10'd600, 1'b0);
    end
    // Window 2: all zeros, cross count restarts at 0, period holds
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, 10'd0, 1'b0);
      if (i == 15) expect_pulse(1'b1, 0, 0, 0, 11, 0);
    end
    // Window 3: thr=0, lo level clamped at 0; gaps between samples
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, w3[i], 1'b0);
      if (i == 15) expect_pulse(1'b1, 0, 9, 2, 4, 4);
      drv(1'b1, 1'b0, 10'd1023, 1'b0);
    end
    // Window 4: constant 1020 while HIGH, no crossing
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, 10'd1020, 1'b0);
      if (i == 15) expect_pulse(1'b1, 1020, 1020, 0, 4, 1020);
    end
    // Window 5: thr=1020, hi level clamped at 1023; 11-bit midpoint sum
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, (i == 1) ? 10'd1023 : 10'd1000, 1'b0);
      if (i == 15) expect_pulse(1'b1, 1000, 1023, 1, 28, 1011);
    end
    drv(1'b1, 1'b0, 10'd0, 1'b0);

    // Drain and confirm every expected pulse arrived
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, 10'd0, 1'b0);
    chk("a_missing_pulses", qa.size(), 0);
    chk("b_missing_pulses", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_wave_monitor.md
# adc_wave_monitor

Receive-side companion to the waveform generators. It accepts a stream of 10-bit converter samples in the `dac_clk` domain and measures them over fixed windows of 2^WIN_LOG2 accepted samples. Per window it reports minimum, maximum, rising-crossing count and period in samples. This closes the loop on the generated waveform, e.g. sawtooth output looped back through an ADC, for self-test and front-panel readout.

## Interface
- WIN_LOG2, 12, log2 of window length in accepted samples (allowed 4..16)
- HYST, 8, hysteresis half-width in LSBs around the crossing threshold (0..255)
- dac_clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-high
- sample_valid  input  1  qualifies `sample` this cycle
- sample  input  10  unsigned converter code
- meas_valid  output  1  one-cycle pulse: result outputs updated
- min_out  output  10  minimum sample of last completed window
- max_out  output  10  maximum sample of last completed window
- cross_cnt  output  8  rising crossings in last window, saturates at 255
- period_out  output  16  samples between the two most recent rising crossings; 0 if fewer than two crossings since reset; saturates at 65535
- thr_out  output  10  threshold currently in use

## Operation
- Decided: one clock, `dac_clk`; reset `rst` is synchronous and active-high.
- Only cycles with `sample_valid`=1 advance any counter, tracker or state. Idle cycles change nothing except the `meas_valid` deassert.
- Window counter wcnt (WIN_LOG2 bits) increments per accepted sample. The sample accepted with wcnt = 2^WIN_LOG2−1 is the window's last sample.
- Running min/max:
  - First sample of a window loads both trackers directly.
  - Later samples update with compare (≤ min, ≥ max).
- Threshold thr:
  - Reset value 512.
  - At each window close, thr ← (min+max)>>1, computed with an 11-bit sum.
  - The new thr applies from the next accepted sample.
- Levels: hi_lvl = min(thr+HYST, 1023); lo_lvl = max(thr−HYST, 0). Both use 11-bit signed-safe arithmetic.
- Crossing FSM, two states:
  - LOW (reset state) → HIGH when sample ≥ hi_lvl. This transition is a rising crossing.
  - HIGH → LOW when sample ≤ lo_lvl.
  - Otherwise the state holds.
- Period:
  - scnt (16 bits) counts accepted samples since the last crossing, saturating at 65535.
  - On a crossing, if a previous crossing exists since reset, last_period ← min(scnt+1, 65535). Then scnt ← 0 and seen_edge ← 1.
- Crossing counter: increments per crossing within the window, saturates at 255, and restarts at the window boundary. If the window's last sample is itself a crossing, it is counted in the closing window. The next window starts at 0.
- Window close, on the last sample's accepting edge:
  - min_out, max_out and cross_cnt take the window values, including that last sample.
  - period_out ← last_period, including an update caused by that sample.
  - meas_valid = 1 for exactly the following cycle.
- Results hold between pulses.
- scnt, seen_edge and FSM state carry across window boundaries. Only min/max/cross trackers restart.

## Timing
- Reset values:
  - Outputs: meas_valid 0, min_out 0, max_out 0, cross_cnt 0, period_out 0, thr_out 512.
  - Internals: FSM LOW, wcnt 0, scnt 0, seen_edge 0.
- Latency: meas_valid is high in the cycle immediately after the edge that accepted sample index 2^WIN_LOG2−1. All result outputs are valid in that same cycle.
- `rst` asserted mid-window discards the partial window. No meas_valid is produced for it. The first post-reset accepted sample is window index 0.
- `rst` has priority over sample_valid in the same cycle.
- Throughput: one sample per cycle sustained, with no backpressure.
- Input gaps of any length are legal and do not affect results.

## Test plan
- Continuous sawtooth 0..1023 (step 1, valid every cycle), WIN_LOG2=12, HYST=8, from reset:
  - Crossings at sample indices 520, 1544, 2568, 3592.
  - Pulse 1 cycle after index 4095 with min 0, max 1023, cross_cnt 4, period 1024.
  - thr_out then becomes 511.
- Same sawtooth with sample_valid toggling 1/0: identical results. meas_valid follows the 4096th accepted sample by 1 cycle.
- Constant 300 for 2 windows: min=max=300, cross_cnt 0, period 0. thr_out becomes 300 after window 1.
- Square wave 0/1023 with half-period 40000 samples, WIN_LOG2=16: period_out 65535 (saturated) once two crossings are seen. cross_cnt counts correctly.
- Sawtooth, `rst` pulsed at sample 2000 of the first window: no pulse at the original boundary. After reset, the first pulse arrives 4096 accepted samples later with thr_out having started at 512.
- WIN_LOG2=4 with a crossing forced exactly at index 15: that crossing is counted in window 1 and period_out reflects it in the same pulse. Window 2 cross_cnt starts at 0.
